// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding imem requester feeding a
// small {addr, instr} buffer in front of the core, with redirect/flush.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned DEPTH        = 2
) (
  input  logic        CLK,
  input  logic        ResetPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   addr_mem  [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic          push;
  logic          pop;
  logic [31:0]   redirect_pc;
  logic          unused_rpc;

  // Low target bits are dropped: fetch is word-aligned.
  assign redirect_pc = {RedirectPC[31:2], 2'b00};
  assign unused_rpc  = ^RedirectPC[1:0];

  assign InstrValid = (count_q != '0);
  assign push = (state_q == FETCH) && imem_ack && !Redirect;
  assign pop  = InstrValid && InstrReady && !Redirect;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    unique case (1'b1)
      Redirect: begin
        count_d  = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end
      push && pop: begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      push && !pop: begin
        count_d  = count_q + CW'(1);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      pop && !push: begin
        count_d  = count_q - CW'(1);
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    unique case (state_q)
      IDLE: begin
        if (Redirect || (count_q < FULL)) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (Redirect) begin
          state_d = imem_ack ? FETCH : DISCARD;
        end else if (imem_ack) begin
          state_d = (count_d < FULL) ? FETCH : IDLE;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (Redirect) begin
      fpc_d = redirect_pc;
    end else if (push) begin
      fpc_d = fpc_q + 32'd4;
    end
  end

  // A stale request keeps its own address until its ack arrives.
  assign req_addr_d = (state_d == FETCH) ? fpc_d : req_addr_q;

  always_ff @(posedge CLK) begin
    if (!ResetPC) begin
      state_q    <= IDLE;
      fpc_q      <= RESET_VECTOR;
      req_addr_q <= RESET_VECTOR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      req_addr_q <= req_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (ResetPC && push) begin
      addr_mem[wr_ptr_q]  <= fpc_q;
      instr_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_req    = (state_q != IDLE);
  assign imem_addr   = req_addr_q;
  assign Instruction = InstrValid ? instr_mem[rd_ptr_q] : NOP;
  assign PC          = InstrValid ? addr_mem[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, backpressure,
// redirects in every state, address wrap and mid-request reset.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        ResetPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic        InstrValid;
  logic        InstrReady;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        ack_en;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always #5 CLK = ~CLK;

  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = exp_instr(imem_addr);

  instruction_fetch_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .DEPTH(2)
  ) dut (
    .CLK(CLK),
    .ResetPC(ResetPC),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .Instruction(Instruction),
    .PC(PC),
    .InstrValid(InstrValid),
    .InstrReady(InstrReady),
    .Redirect(Redirect),
    .RedirectPC(RedirectPC)
  );

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    ResetPC = 1'b0; ack_en = 1'b0; InstrReady = 1'b0;
    Redirect = 1'b0; RedirectPC = '0;
    step; step;
    ResetPC = 1'b1;
    step;
  endtask

  task automatic test_reset;
    ResetPC = 1'b0; ack_en = 1'b0; InstrReady = 1'b0;
    Redirect = 1'b0; RedirectPC = '0;
    step; step;
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++;
    if (InstrValid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b exp 0", InstrValid); end
    checks++;
    if (Instruction !== NOP) begin failures++; $display("FAIL rst_instr got %h exp %h", Instruction, NOP); end
    checks++;
    if (PC !== 32'h0) begin failures++; $display("FAIL rst_pc got %h exp 0", PC); end
    ResetPC = 1'b1;
    step;
    checks++;
    if (imem_req !== 1'b1) begin failures++; $display("FAIL rel_req got %b exp 1", imem_req); end
    checks++;
    if (imem_addr !== 32'h0) begin failures++; $display("FAIL rel_addr got %h exp 0", imem_addr); end
    checks++;
    if (InstrValid !== 1'b0) begin failures++; $display("FAIL rel_valid got %b exp 0", InstrValid); end
  endtask

  task automatic test_stream;
    logic [31:0] a;
    do_reset;
    ack_en = 1'b1; InstrReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 32'(4 * i);
      checks++;
      if (imem_addr !== a || imem_req !== 1'b1) begin
        failures++; $display("FAIL stream_addr[%0d] got %h req %b exp %h", i, imem_addr, imem_req, a);
      end
      step;
      checks++;
      if (InstrValid !== 1'b1 || PC !== a || Instruction !== exp_instr(a)) begin
        failures++;
        $display("FAIL stream_head[%0d] got v=%b pc=%h i=%h exp pc=%h i=%h",
                 i, InstrValid, PC, Instruction, a, exp_instr(a));
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    InstrReady = 1'b0; ack_en = 1'b1;
    step;
    checks++;
    if (InstrValid !== 1'b1 || PC !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      failures++; $display("FAIL bp_first got v=%b pc=%h req=%b addr=%h", InstrValid, PC, imem_req, imem_addr);
    end
    step;
    checks++;
    if (imem_req !== 1'b0 || PC !== 32'h0) begin
      failures++; $display("FAIL bp_full got req=%b pc=%h exp 0/0", imem_req, PC);
    end
    step; step;
    checks++;
    if (imem_req !== 1'b0 || InstrValid !== 1'b1 || PC !== 32'h0) begin
      failures++; $display("FAIL bp_hold got req=%b v=%b pc=%h", imem_req, InstrValid, PC);
    end
    InstrReady = 1'b1;
    step;
    checks++;
    if (PC !== 32'h4 || Instruction !== exp_instr(32'h4) || imem_req !== 1'b0) begin
      failures++; $display("FAIL bp_pop got pc=%h i=%h req=%b", PC, Instruction, imem_req);
    end
    step;
    checks++;
    if (InstrValid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      failures++; $display("FAIL bp_resume got v=%b req=%b addr=%h exp 0/1/8", InstrValid, imem_req, imem_addr);
    end
    step;
    checks++;
    if (InstrValid !== 1'b1 || PC !== 32'h8 || Instruction !== exp_instr(32'h8)) begin
      failures++; $display("FAIL bp_next got v=%b pc=%h i=%h", InstrValid, PC, Instruction);
    end
  endtask

  task automatic test_redirect_idle;
    do_reset;
    InstrReady = 1'b0; ack_en = 1'b1;
    step; step;
    Redirect = 1'b1; RedirectPC = 32'h0000_0041; InstrReady = 1'b1;
    step;
    Redirect = 1'b0;
    checks++;
    if (InstrValid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      failures++; $display("FAIL rdi_flush got v=%b req=%b addr=%h exp 0/1/40", InstrValid, imem_req, imem_addr);
    end
    step;
    checks++;
    if (InstrValid !== 1'b1 || PC !== 32'h40) begin
      failures++; $display("FAIL rdi_push got v=%b pc=%h exp 1/40", InstrValid, PC);
    end
  endtask

  task automatic test_redirect_wait;
    do_reset;
    InstrReady = 1'b1; ack_en = 1'b1;
    step; step;
    ack_en = 1'b0; Redirect = 1'b1; RedirectPC = 32'h0000_0103;
    step;
    Redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || InstrValid !== 1'b0) begin
        failures++;
        $display("FAIL rdw_hold[%0d] got req=%b addr=%h v=%b exp 1/8/0", i, imem_req, imem_addr, InstrValid);
      end
      if (i == 2) ack_en = 1'b1;
      step;
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || InstrValid !== 1'b0) begin
      failures++; $display("FAIL rdw_new got req=%b addr=%h v=%b exp 1/100/0", imem_req, imem_addr, InstrValid);
    end
    step;
    checks++;
    if (InstrValid !== 1'b1 || PC !== 32'h100 || Instruction !== exp_instr(32'h100)) begin
      failures++; $display("FAIL rdw_push got v=%b pc=%h i=%h", InstrValid, PC, Instruction);
    end
  endtask

  task automatic test_discard_redirect;
    do_reset;
    InstrReady = 1'b1; ack_en = 1'b0;
    Redirect = 1'b1; RedirectPC = 32'h0000_0300;
    step;
    RedirectPC = 32'h0000_0500;
    step;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || InstrValid !== 1'b0) begin
      failures++; $display("FAIL dsc_hold got req=%b addr=%h v=%b exp 1/0/0", imem_req, imem_addr, InstrValid);
    end
    RedirectPC = 32'h0000_0600; ack_en = 1'b1;
    step;
    Redirect = 1'b0;
    checks++;
    if (imem_addr !== 32'h600 || InstrValid !== 1'b0) begin
      failures++; $display("FAIL dsc_end got addr=%h v=%b exp 600/0", imem_addr, InstrValid);
    end
    step;
    checks++;
    if (InstrValid !== 1'b1 || PC !== 32'h600) begin
      failures++; $display("FAIL dsc_push got v=%b pc=%h exp 1/600", InstrValid, PC);
    end
  endtask

  task automatic test_redirect_ack;
    do_reset;
    InstrReady = 1'b1; ack_en = 1'b1;
    step;
    Redirect = 1'b1; RedirectPC = 32'h0000_0203;
    step;
    Redirect = 1'b0;
    checks++;
    if (InstrValid !== 1'b0 || Instruction !== NOP || PC !== 32'h0) begin
      failures++; $display("FAIL rda_flush got v=%b i=%h pc=%h", InstrValid, Instruction, PC);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      failures++; $display("FAIL rda_addr got req=%b addr=%h exp 1/200", imem_req, imem_addr);
    end
    step;
    checks++;
    if (InstrValid !== 1'b1 || PC !== 32'h200) begin
      failures++; $display("FAIL rda_push got v=%b pc=%h exp 1/200", InstrValid, PC);
    end
  endtask

  task automatic test_wrap;
    do_reset;
    InstrReady = 1'b1; ack_en = 1'b1;
    Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFE;
    step;
    Redirect = 1'b0;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC || InstrValid !== 1'b0) begin
      failures++; $display("FAIL wrap_tgt got addr=%h v=%b exp fffffffc/0", imem_addr, InstrValid);
    end
    step;
    checks++;
    if (PC !== 32'hFFFF_FFFC || Instruction !== exp_instr(32'hFFFF_FFFC) || imem_addr !== 32'h0) begin
      failures++; $display("FAIL wrap_last got pc=%h i=%h addr=%h", PC, Instruction, imem_addr);
    end
    step;
    checks++;
    if (InstrValid !== 1'b1 || PC !== 32'h0 || Instruction !== exp_instr(32'h0)) begin
      failures++; $display("FAIL wrap_zero got v=%b pc=%h i=%h", InstrValid, PC, Instruction);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    InstrReady = 1'b1; ack_en = 1'b1;
    step; step; step;
    checks++;
    if (imem_addr !== 32'hC || PC !== 32'h8) begin
      failures++; $display("FAIL rsm_pre got addr=%h pc=%h exp c/8", imem_addr, PC);
    end
    ResetPC = 1'b0;
    step;
    checks++;
    if (imem_req !== 1'b0 || InstrValid !== 1'b0 || Instruction !== NOP || PC !== 32'h0) begin
      failures++; $display("FAIL rsm_rst got req=%b v=%b i=%h pc=%h", imem_req, InstrValid, Instruction, PC);
    end
    ResetPC = 1'b1;
    step;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || InstrValid !== 1'b0) begin
      failures++; $display("FAIL rsm_restart got req=%b addr=%h v=%b exp 1/0/0", imem_req, imem_addr, InstrValid);
    end
    step;
    checks++;
    if (InstrValid !== 1'b1 || PC !== 32'h0 || Instruction !== exp_instr(32'h0)) begin
      failures++; $display("FAIL rsm_push got v=%b pc=%h i=%h", InstrValid, PC, Instruction);
    end
  endtask

  initial begin
    ResetPC = 1'b0; ack_en = 1'b0; InstrReady = 1'b0;
    Redirect = 1'b0; RedirectPC = '0;
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect_idle;
    test_redirect_wait;
    test_discard_redirect;
    test_redirect_ack;
    test_wrap;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
